systolic_cs_acc_array: RTL

//  SIZE x SIZE carry-save systolic MAC array with pipelined per-column final CPA and group accumulator.

---
 rtl/systolic_pkg.sv | 46 ++++
 rtl/systolic_cs_acc_array_if.sv | 30 +++
 rtl/cs_mac_pe.sv | 45 ++++
 rtl/systolic_cs_acc_array.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and elaboration helpers for the carry-save systolic MAC array.
package systolic_pkg;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
    logic smode;
  } beat_tag_t;

  typedef enum logic {
    ACC_IDLE,
    ACC_ACCUM
  } acc_state_t;

  function automatic int clog2_f(int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int acc_w_default(int size, int dw);
    return 2 * dw + size;
  endfunction

  function automatic int acc_w_min(int size, int dw);
    return 2 * dw + clog2_f(size);
  endfunction

  function automatic int rot_default(int size);
    return size / 2 + 1;
  endfunction

  function automatic int gcd_f(int a, int b);
    int x = a;
    int y = b;
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

endpackage

// File: rtl/systolic_cs_acc_array_if.sv
// Operand beat stream in, group result stream out, for the systolic MAC array.
interface systolic_cs_acc_array_if
  import systolic_pkg::*;
#(
  parameter int SIZE  = 4,
  parameter int DW    = 8,
  parameter int ACC_W = acc_w_default(SIZE, DW)
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_first;
  logic                  in_last;
  logic                  signed_mode;
  logic [SIZE*DW-1:0]    weight;
  logic [SIZE*DW-1:0]    act;
  logic                  out_valid;
  logic                  out_ready;
  logic [SIZE*ACC_W-1:0] result;
  logic [SIZE-1:0]       overflow;

  modport master (
    output in_valid, in_first, in_last, signed_mode, weight, act, out_ready,
    input  in_ready, out_valid, result, overflow
  );

  modport slave (
    input  in_valid, in_first, in_last, signed_mode, weight, act, out_ready,
    output in_ready, out_valid, result, overflow
  );
endinterface

// File: rtl/cs_mac_pe.sv
// One array cell: DW x DW multiply folded into a carry-save (sum, carry) partial-sum pair.
module cs_mac_pe #(
  parameter int DW    = 8,
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             en,
  input  logic             smode,
  input  logic [DW-1:0]    w_in,
  input  logic [DW-1:0]    a_in,
  input  logic [ACC_W-1:0] ps_in,
  input  logic [ACC_W-1:0] pc_in,
  output logic [DW-1:0]    w_out,
  output logic [DW-1:0]    a_out,
  output logic [ACC_W-1:0] ps_out,
  output logic [ACC_W-1:0] pc_out
);

  logic signed [DW:0]     w_x;
  logic signed [DW:0]     a_x;
  logic signed [2*DW+1:0] prod;
  logic [ACC_W-1:0]       p;
  logic [ACC_W-1:0]       s;
  logic [ACC_W-1:0]       maj;

  // One extra operand bit makes a single signed multiplier serve both modes.
  assign w_x  = {smode & w_in[DW-1], w_in};
  assign a_x  = {smode & a_in[DW-1], a_in};
  assign prod = (2*DW+2)'(w_x) * (2*DW+2)'(a_x);
  assign p    = ACC_W'(prod);

  assign s    = ps_in ^ pc_in ^ p;
  assign maj  = (ps_in & pc_in) | (ps_in & p) | (pc_in & p);

  // NOTE: datapath registers have no reset; the travelling valid tag decides whether they matter.
  always_ff @(posedge clk) begin
    if (en) begin
      w_out  <= w_in;
      a_out  <= a_in;
      ps_out <= s;
      pc_out <= maj << 1;
    end
  end

endmodule

// File: rtl/systolic_cs_acc_array.sv
// SIZE x SIZE carry-save systolic MAC array with per-column CPA and a tagged group accumulator.
module systolic_cs_acc_array
  import systolic_pkg::*;
#(
  parameter int SIZE  = 4,
  parameter int DW    = 8,
  parameter int ROT   = rot_default(SIZE),
  parameter int ACC_W = acc_w_default(SIZE, DW)
) (
  input logic clk,
  input logic rst,
  systolic_cs_acc_array_if.slave bus
);

  if (gcd_f(ROT, SIZE) != 1) begin : g_rot_check
    $error("ROT must be coprime with SIZE");
  end
  if (ACC_W < acc_w_min(SIZE, DW)) begin : g_accw_check
    $error("ACC_W too narrow for SIZE products of 2*DW bits");
  end

  logic                  adv;
  logic                  accept;
  logic                  in_open;
  logic                  in_mode;
  logic                  eff_mode;
  beat_tag_t             in_tag;
  beat_tag_t             stage_tag;
  beat_tag_t             cpa_tag;
  beat_tag_t             tag_r [SIZE];
  logic [SIZE*DW-1:0]    w_stage;
  logic [SIZE*DW-1:0]    a_stage;
  logic [DW-1:0]         w_r  [SIZE][SIZE];
  logic [DW-1:0]         a_r  [SIZE][SIZE];
  logic [ACC_W-1:0]      ps_r [SIZE][SIZE];
  logic [ACC_W-1:0]      pc_r [SIZE][SIZE];
  logic [ACC_W-1:0]      cpa_sum [SIZE];

  acc_state_t            state;
  acc_state_t            state_next;
  logic [ACC_W-1:0]      acc_q    [SIZE];
  logic [ACC_W-1:0]      acc_next [SIZE];
  logic [ACC_W:0]        add_w    [SIZE];
  logic [SIZE-1:0]       wrap;
  logic [SIZE-1:0]       ovf_q;
  logic [SIZE-1:0]       ovf_next;
  logic                  emit;
  logic                  out_valid_r;
  logic [SIZE*ACC_W-1:0] result_r;
  logic [SIZE-1:0]       overflow_r;

  assign adv          = !out_valid_r || bus.out_ready;
  assign bus.in_ready = adv && !rst;
  assign accept       = bus.in_valid && bus.in_ready;

  // Later beats of a group inherit the opening beat's mode, so extension is uniform per group.
  assign eff_mode = (bus.in_first || !in_open) ? bus.signed_mode : in_mode;
  assign in_tag   = '{valid: accept, first: bus.in_first, last: bus.in_last, smode: eff_mode};

  always_ff @(posedge clk) begin
    if (rst) begin
      in_open   <= 1'b0;
      in_mode   <= 1'b0;
      stage_tag <= '0;
      for (int k = 0; k < SIZE; k++) tag_r[k] <= '0;
      cpa_tag   <= '0;
    end else if (adv) begin
      if (accept) begin
        in_open <= !bus.in_last;
        in_mode <= eff_mode;
      end
      stage_tag <= in_tag;
      tag_r[0]  <= stage_tag;
      for (int k = 1; k < SIZE; k++) tag_r[k] <= tag_r[k-1];
      cpa_tag   <= tag_r[SIZE-1];
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      w_stage <= bus.weight;
      a_stage <= bus.act;
      for (int i = 0; i < SIZE; i++) cpa_sum[i] <= ps_r[SIZE-1][i] + pc_r[SIZE-1][i];
    end
  end

  for (genvar j = 0; j < SIZE; j++) begin : g_row
    for (genvar i = 0; i < SIZE; i++) begin : g_col
      localparam int SRC = (i + ROT) % SIZE;
      logic [DW-1:0]    w_src;
      logic [DW-1:0]    a_src;
      logic [ACC_W-1:0] ps_src;
      logic [ACC_W-1:0] pc_src;
      logic             m_src;

      if (j == 0) begin : g_first
        assign w_src  = w_stage[i*DW +: DW];
        assign a_src  = a_stage[i*DW +: DW];
        assign ps_src = '0;
        assign pc_src = '0;
        assign m_src  = stage_tag.smode;
      end else begin : g_next
        assign w_src  = w_r[j-1][i];
        assign a_src  = a_r[j-1][SRC];
        assign ps_src = ps_r[j-1][i];
        assign pc_src = pc_r[j-1][i];
        assign m_src  = tag_r[j-1].smode;
      end

      cs_mac_pe #(.DW(DW), .ACC_W(ACC_W)) u_pe (
        .clk    (clk),
        .en     (adv),
        .smode  (m_src),
        .w_in   (w_src),
        .a_in   (a_src),
        .ps_in  (ps_src),
        .pc_in  (pc_src),
        .w_out  (w_r[j][i]),
        .a_out  (a_r[j][i]),
        .ps_out (ps_r[j][i]),
        .pc_out (pc_r[j][i])
      );
    end
  end

  // NOTE: every always_comb output is assigned a default first, so no latch can be inferred.
  always_comb begin
    state_next = state;
    emit       = 1'b0;
    ovf_next   = ovf_q;
    for (int i = 0; i < SIZE; i++) begin
      acc_next[i] = acc_q[i];
      add_w[i]    = {1'b0, acc_q[i]} + {1'b0, cpa_sum[i]};
      wrap[i]     = cpa_tag.smode
                  ? (acc_q[i][ACC_W-1] == cpa_sum[i][ACC_W-1]) &&
                    (add_w[i][ACC_W-1] != acc_q[i][ACC_W-1])
                  : add_w[i][ACC_W];
    end
    if (adv && cpa_tag.valid) begin
      if (state == ACC_IDLE || cpa_tag.first) begin
        for (int i = 0; i < SIZE; i++) acc_next[i] = cpa_sum[i];
        ovf_next = '0;
      end else begin
        for (int i = 0; i < SIZE; i++) acc_next[i] = add_w[i][ACC_W-1:0];
        ovf_next = ovf_q | wrap;
      end
      state_next = cpa_tag.last ? ACC_IDLE : ACC_ACCUM;
      emit       = cpa_tag.last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ACC_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    acc_q <= acc_next;
    ovf_q <= ovf_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      result_r    <= '0;
      overflow_r  <= '0;
    end else if (adv) begin
      out_valid_r <= emit;
      if (emit) begin
        for (int i = 0; i < SIZE; i++) result_r[i*ACC_W +: ACC_W] <= acc_next[i];
        overflow_r <= ovf_next;
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.overflow  = overflow_r;

endmodule
